// File: rtl/drac_pkg.sv
// rtl/drac_pkg.sv - core-wide byte-address type used as the default prefetcher address
package drac_pkg;
  typedef logic [39:0] addr_t;
endpackage

// File: rtl/hwpf_pkg.sv
// rtl/hwpf_pkg.sv - shared line-tag, queue-entry and candidate types plus line alignment
package hwpf_pkg;
  typedef drac_pkg::addr_t line_tag_t;

  typedef struct packed {
    logic      valid;
    line_tag_t tag;
  } rq_entry_t;

  typedef struct packed {
    line_tag_t addr;
  } pf_cand_t;

  function automatic line_tag_t line_align(input line_tag_t addr, input int line_bytes);
    line_tag_t mask;
    mask = line_tag_t'(line_bytes - 1);
    return addr & ~mask;
  endfunction
endpackage

// File: rtl/hwpf_cand_fifo.sv
// rtl/hwpf_cand_fifo.sv - multi-push candidate FIFO; lanes that find no room are dropped, lowest lane first wins
module hwpf_cand_fifo
  import hwpf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [LANES-1:0]      push_valid,
  input  pf_cand_t [LANES-1:0]  push_data,
  output logic [LANES-1:0]      push_drop,
  output logic                  pop_valid,
  output pf_cand_t              pop_data,
  input  logic                  pop_ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  pf_cand_t       mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  free;
  logic [CW-1:0]  n_push;
  logic [LANES-1:0] accept;
  logic [PW-1:0]  slot [LANES];
  logic           pop;

  assign pop_valid = (count != '0);
  assign pop       = pop_valid && pop_ready;
  // Gate the head so the output reads zero while empty, including after reset.
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

  always_comb begin
    free      = CW'(DEPTH) - count + CW'(pop);
    n_push    = '0;
    accept    = '0;
    push_drop = '0;
    for (int l = 0; l < LANES; l++) begin
      slot[l] = wr_ptr + PW'(n_push);
      if (push_valid[l]) begin
        if (n_push < free) begin
          accept[l] = 1'b1;
          n_push    = n_push + CW'(1);
        end else begin
          push_drop[l] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= wr_ptr + PW'(n_push);
      count  <= count - CW'(pop) + n_push;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (!rst && !clear && accept[l]) mem[slot[l]] <= push_data[l];
    end
  end
endmodule

// File: rtl/hwpf_recency_filter.sv
// rtl/hwpf_recency_filter.sv - LRU recency filter emitting next-line prefetch candidates on misses
// Optional statistics counters: HWPF_RECENCY_STATS_EN
module hwpf_recency_filter
  import hwpf_pkg::*;
#(
  parameter int  LINE_BYTES = 64,
  parameter int  DEPTH      = 8,
  parameter int  INSERTS    = 2,
  parameter int  PF_DEPTH   = 4,
  parameter type cpu_addr_t = drac_pkg::addr_t
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        lock_i,
  input  logic [INSERTS-1:0]          req_valid_i,
  input  cpu_addr_t [INSERTS-1:0]     req_addr_i,
  output logic [INSERTS-1:0]          resp_valid_o,
  output logic [INSERTS-1:0]          resp_hit_o,
  output logic                        pf_valid_o,
  output cpu_addr_t                   pf_addr_o,
  input  logic                        pf_ready_i
`ifdef HWPF_RECENCY_STATS_EN
  ,
  output logic [31:0]                 stat_hit_o,
  output logic [31:0]                 stat_miss_o,
  output logic [31:0]                 stat_drop_o
`endif
);
  localparam line_tag_t MAX_LINE = line_align(~line_tag_t'(0), LINE_BYTES);

  rq_entry_t            q     [DEPTH];
  rq_entry_t            q_nxt [DEPTH];
  logic [INSERTS-1:0]   take;
  logic [INSERTS-1:0]   hit;
  logic [INSERTS-1:0]   cand_valid;
  logic [INSERTS-1:0]   cand_drop;
  pf_cand_t [INSERTS-1:0] cand;
  pf_cand_t             head;
  line_tag_t            line;
  int                   pos;

  assign take = (flush_i || lock_i) ? '0 : req_valid_i;

  // Lanes are applied in order to a working copy so each lane sees the lower lanes' moves.
  always_comb begin
    q_nxt      = q;
    hit        = '0;
    cand_valid = '0;
    cand       = '0;
    line       = '0;
    pos        = 0;
    for (int i = 0; i < INSERTS; i++) begin
      if (take[i]) begin
        line = line_align(line_tag_t'(req_addr_i[i]), LINE_BYTES);
        pos  = DEPTH - 1;
        for (int j = DEPTH - 1; j >= 0; j--) begin
          if (q_nxt[j].valid && q_nxt[j].tag == line) begin
            hit[i] = 1'b1;
            pos    = j;
          end
        end
        // A miss uses pos = LRU, so the whole queue shifts and the LRU falls off.
        for (int j = DEPTH - 1; j > 0; j--) begin
          if (j <= pos) q_nxt[j] = q_nxt[j-1];
        end
        q_nxt[0] = '{valid: 1'b1, tag: line};
        if (!hit[i] && line != MAX_LINE) begin
          cand_valid[i] = 1'b1;
          cand[i].addr  = line + line_tag_t'(LINE_BYTES);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < DEPTH; j++) q[j] <= '0;
      resp_valid_o <= '0;
      resp_hit_o   <= '0;
    end else if (flush_i) begin
      for (int j = 0; j < DEPTH; j++) q[j].valid <= 1'b0;
      resp_valid_o <= '0;
      resp_hit_o   <= '0;
    end else begin
      q            <= q_nxt;
      resp_valid_o <= take;
      resp_hit_o   <= hit;
    end
  end

  hwpf_cand_fifo #(
    .DEPTH (PF_DEPTH),
    .LANES (INSERTS)
  ) u_cand_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (flush_i),
    .push_valid (cand_valid),
    .push_data  (cand),
    .push_drop  (cand_drop),
    .pop_valid  (pf_valid_o),
    .pop_data   (head),
    .pop_ready  (pf_ready_i)
  );

  assign pf_addr_o = cpu_addr_t'(head.addr);

`ifdef HWPF_RECENCY_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [INSERTS-1:0] lanes);
    logic [32:0] sum;
    sum = {1'b0, acc} + 33'($countones(lanes));
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_hit_o  <= '0;
      stat_miss_o <= '0;
      stat_drop_o <= '0;
    end else begin
      stat_hit_o  <= sat_add(stat_hit_o, take & hit);
      stat_miss_o <= sat_add(stat_miss_o, take & ~hit);
      stat_drop_o <= sat_add(stat_drop_o, cand_drop);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = ^cand_drop;
`endif
endmodule

// File: tb/tb_hwpf_recency_filter.sv
// tb/tb_hwpf_recency_filter.sv - directed and random checks against a queue-based recency model
module tb_hwpf_recency_filter;
  localparam int DEPTH    = 8;
  localparam int PF_DEPTH = 4;
  localparam int LB       = 64;
  localparam logic [39:0] LINE_MASK = ~40'h3F;
  localparam logic [39:0] MAX_LINE  = 40'hFF_FFFF_FFC0;

  logic clk = 1'b0;
  logic rst, flush, lock, pf_ready;
  logic [1:0]       req_valid;
  logic [1:0][39:0] req_addr;
  logic [1:0]       resp_valid, resp_hit;
  logic             pf_valid;
  logic [39:0]      pf_addr;
`ifdef HWPF_RECENCY_STATS_EN
  logic [31:0] stat_hit, stat_miss, stat_drop;
  logic [31:0] drop0;
`endif

  int tests = 0;
  int fails = 0;
  logic [39:0] lru[$];
  logic [39:0] pfq[$];
  logic [1:0]  exp_rv, exp_hit;
  int m_hit = 0, m_miss = 0, m_drop = 0;

  always #5 clk = ~clk;

  hwpf_recency_filter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .lock_i       (lock),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .resp_valid_o (resp_valid),
    .resp_hit_o   (resp_hit),
    .pf_valid_o   (pf_valid),
    .pf_addr_o    (pf_addr),
    .pf_ready_i   (pf_ready)
`ifdef HWPF_RECENCY_STATS_EN
    ,
    .stat_hit_o   (stat_hit),
    .stat_miss_o  (stat_miss),
    .stat_drop_o  (stat_drop)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: MRU-first queue of lines and a FIFO queue of candidates.
  task automatic model(input logic r, input logic fl, input logic lk, input logic rd,
                       input logic [1:0] v, input logic [1:0][39:0] a);
    logic [39:0] ln;
    int idx;
    exp_rv  = '0;
    exp_hit = '0;
    if (r) begin
      lru.delete(); pfq.delete();
      m_hit = 0; m_miss = 0; m_drop = 0;
      return;
    end
    if (fl) begin
      lru.delete(); pfq.delete();
      return;
    end
    if (rd && pfq.size() > 0) void'(pfq.pop_front());
    if (lk) return;
    for (int i = 0; i < 2; i++) begin
      if (v[i]) begin
        ln  = a[i] & LINE_MASK;
        idx = -1;
        foreach (lru[k]) if (lru[k] == ln) idx = k;
        exp_rv[i] = 1'b1;
        if (idx >= 0) begin
          exp_hit[i] = 1'b1;
          m_hit++;
          lru.delete(idx);
        end else begin
          m_miss++;
          if (lru.size() == DEPTH) void'(lru.pop_back());
          if (ln != MAX_LINE) begin
            if (pfq.size() < PF_DEPTH) pfq.push_back(ln + 40'(LB));
            else m_drop++;
          end
        end
        lru.push_front(ln);
      end
    end
  endtask

  task automatic step(input logic r, input logic fl, input logic lk, input logic rd,
                      input logic [1:0] v, input logic [39:0] a0, input logic [39:0] a1);
    rst = r; flush = fl; lock = lk; pf_ready = rd;
    req_valid = v; req_addr[0] = a0; req_addr[1] = a1;
    model(r, fl, lk, rd, v, {a1, a0});
    @(posedge clk); #1;
    chk("resp_valid", resp_valid, exp_rv);
    chk("resp_hit", resp_hit, exp_hit);
    chk("pf_valid", pf_valid, pfq.size() != 0);
    chk("pf_addr", pf_addr, (pfq.size() != 0) ? pfq[0] : 40'h0);
  endtask

  initial begin
    logic [1:0]  rv;
    logic [39:0] ra [2];
    int pick;
    rst = 1'b1; flush = 1'b0; lock = 1'b0; pf_ready = 1'b0;
    req_valid = '0; req_addr = '0;

    step(1, 0, 0, 0, 2'b00, 40'h0, 40'h0);
    step(1, 0, 0, 0, 2'b11, 40'h1234, 40'h5678);
    chk("reset_pf_addr", pf_addr, 40'h0);

    step(0, 0, 0, 0, 2'b01, 40'h1000, 40'h0);
    chk("r045_hit", resp_hit[0], 1'b0);
    chk("r045_pf", pf_addr, 40'h1040);
    step(0, 0, 0, 1, 2'b00, 40'h0, 40'h0);

    step(0, 1, 0, 1, 2'b00, 40'h0, 40'h0);
    step(0, 0, 0, 0, 2'b11, 40'h1008, 40'h1030);
    chk("r046_hits", resp_hit, 2'b10);
    chk("r046_pf", pf_addr, 40'h1040);
    step(0, 0, 0, 1, 2'b00, 40'h0, 40'h0);
    chk("r046_one_cand", pf_valid, 1'b0);

    step(0, 1, 0, 1, 2'b00, 40'h0, 40'h0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1, 2'b01, 40'h4000 + 40'(i * LB), 40'h0);
    step(0, 0, 0, 1, 2'b01, 40'h4040, 40'h0);
    chk("r047_second_hit", resp_hit[0], 1'b1);
    step(0, 0, 0, 1, 2'b01, 40'h4000, 40'h0);
    chk("r047_first_miss", resp_hit[0], 1'b0);

    step(0, 1, 0, 1, 2'b00, 40'h0, 40'h0);
`ifdef HWPF_RECENCY_STATS_EN
    drop0 = stat_drop;
`endif
    for (int i = 0; i < PF_DEPTH + 2; i++) step(0, 0, 0, 0, 2'b01, 40'h8000 + 40'(i * 128), 40'h0);
    chk("r048_head", pf_addr, 40'h8040);
`ifdef HWPF_RECENCY_STATS_EN
    chk("r048_drops", stat_drop - drop0, 32'd2);
`endif
    for (int i = 0; i < PF_DEPTH + 1; i++) step(0, 0, 0, 1, 2'b00, 40'h0, 40'h0);

    step(0, 1, 0, 1, 2'b00, 40'h0, 40'h0);
    step(0, 0, 0, 1, 2'b01, 40'h5000, 40'h0);
    step(0, 0, 0, 1, 2'b01, 40'h6000, 40'h0);
    step(0, 0, 1, 1, 2'b11, 40'h7000, 40'h5000);
    chk("r049_lock_rv", resp_valid, 2'b00);
    step(0, 0, 0, 1, 2'b01, 40'h6000, 40'h0);
    chk("r049_mru_hit", resp_hit[0], 1'b1);
    step(0, 0, 0, 1, 2'b01, 40'h7000, 40'h0);
    chk("r049_locked_line_absent", resp_hit[0], 1'b0);

    step(0, 1, 0, 1, 2'b00, 40'h0, 40'h0);
    step(0, 0, 0, 1, 2'b01, 40'h2000, 40'h0);
    step(0, 1, 0, 1, 2'b01, 40'h2000, 40'h0);
    chk("r050_flush_rv", resp_valid[0], 1'b0);
    step(0, 0, 0, 1, 2'b01, 40'h2000, 40'h0);
    chk("r050_miss", resp_hit[0], 1'b0);

    step(0, 0, 0, 1, 2'b00, 40'h0, 40'h0);
    step(0, 0, 0, 1, 2'b01, MAX_LINE + 40'h8, 40'h0);
    chk("maxline_no_cand", pf_valid, 1'b0);

    step(0, 0, 0, 0, 2'b11, 40'h9000, 40'hA000);
    step(1, 0, 0, 0, 2'b01, 40'h9000, 40'h0);
    chk("midreset_rv", resp_valid, 2'b00);

    for (int n = 0; n < 400; n++) begin
      rv = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        pick  = int'($urandom_range(0, 13));
        ra[k] = (pick == 13) ? MAX_LINE + 40'($urandom_range(0, 63))
                             : 40'h3000 + 40'(pick * LB) + 40'($urandom_range(0, 63));
      end
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), rv, ra[0], ra[1]);
    end

`ifdef HWPF_RECENCY_STATS_EN
    chk("stat_hit", stat_hit, 32'(m_hit));
    chk("stat_miss", stat_miss, 32'(m_miss));
    chk("stat_drop", stat_drop, 32'(m_drop));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
